// File: rtl/seg7_pkg.sv
// Shared segment constants for the 7-segment scan driver.
// Patterns are active-high, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high segment pattern.
// Codes 10..15 render as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0]       code,
  output logic [SEG_W-1:0] seg
);

  // Map one 4-bit code to its segment pattern
  always_comb begin
    seg = SEG_DASH;
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with frame-aligned updates.
// Optional leading-zero blanking: define SEG7_SCAN_LZB_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [SEG_W-1:0]      seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

  logic [PW-1:0]        pcnt;
  logic [IW-1:0]        idx;
  logic [4*DIGITS-1:0]  disp;
  logic [4*DIGITS-1:0]  pend;
  logic                 pflag;

  logic                 digit_end;
  logic                 frame_end;

  logic [3:0]           cur;
  logic [SEG_W-1:0]     dec;
  logic                 blank;
  logic [SEG_W-1:0]     pix;
  logic [DIGITS-1:0]    an_next;

  logic [SEG_W-1:0]     seg_q;
  logic [DIGITS-1:0]    an_q;
  logic                 bnd_q;
  logic                 tick_q;

  assign digit_end = (pcnt == PMAX);
  assign frame_end = digit_end && (idx == IMAX);

  // Prescaler and digit index scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      if (digit_end) begin
        pcnt <= '0;
        idx  <= (idx == IMAX) ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Shadow register: loads wait for the frame edge unless they hit it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp  <= '0;
      pend  <= '0;
      pflag <= 1'b0;
    end else if (load) begin
      pend <= bcd_in;
      if (frame_end) begin
        disp  <= bcd_in;
        pflag <= 1'b0;
      end else begin
        pflag <= 1'b1;
      end
    end else if (frame_end && pflag) begin
      disp  <= pend;
      pflag <= 1'b0;
    end
  end

  // Select the digit being scanned and its one-hot enable
  always_comb begin
    cur     = '0;
    an_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur        = disp[4*i +: 4];
        an_next[i] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .code (cur),
    .seg  (dec)
  );

`ifdef SEG7_SCAN_LZB_EN
  // Blank digit d>=1 when it and all more-significant digits are zero
  always_comb begin
    logic zrun;
    zrun  = 1'b1;
    blank = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zrun = zrun && (disp[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) begin
        blank = zrun;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign pix = blank ? SEG_BLANK : dec;

  // Registered pins; the tick is delayed so it lines up with new data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q  <= '0;
      an_q   <= '0;
      bnd_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= pix;
      an_q   <= an_next;
      bnd_q  <= frame_end;
      tick_q <= bnd_q;
    end
  end

  assign seg_out    = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign an_out     = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
  assign frame_tick = tick_q;
  assign pending    = pflag;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, PRESCALE=4).
// Two instances: active-high pins and fully active-low pins.
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int P = 4;
  localparam int F = D * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;

  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;
  logic        pend_a, pend_b;
  logic        tick_a, tick_b;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS(D), .PRESCALE(P),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) u_a (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .seg_out(seg_a), .an_out(an_a),
    .pending(pend_a), .frame_tick(tick_a)
  );

  seg7_scan_driver #(
    .DIGITS(D), .PRESCALE(P),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) u_b (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .seg_out(seg_b), .an_out(an_b),
    .pending(pend_b), .frame_tick(tick_b)
  );

  int errors = 0;
  int checks = 0;

  // Model state: cycles since reset release, values, pin expectation
  int          t;
  logic [15:0] mdisp, mpend;
  bit          mpf;
  bit          last_bnd;
  int          e_pos;
  logic [15:0] e_val;
  bit          e_tick;

  logic [6:0] pat [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] exp_seg(int pos, logic [15:0] v);
    int dv;
    if (pos < 0) return 7'h00;
    dv = int'((v >> (4*pos)) & 16'hF);
`ifdef SEG7_SCAN_LZB_EN
    if (pos > 0 && (v >> (4*pos)) == 16'h0) return 7'h00;
`endif
    if (dv > 9) return 7'h40;
    return pat[dv];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    t = 0; mdisp = '0; mpend = '0; mpf = 0;
    last_bnd = 0; e_pos = -1; e_val = '0; e_tick = 0;
  endtask

  task automatic compare_all();
    logic [6:0] es, es_n;
    logic [3:0] ea, ea_n;
    es   = exp_seg(e_pos, e_val);
    es_n = ~es;
    ea   = (e_pos < 0) ? 4'h0 : 4'(1 << e_pos);
    ea_n = ~ea;
    chk("seg_a", seg_a, es);
    chk("an_a", an_a, ea);
    chk("tick_a", tick_a, e_tick);
    chk("pend_a", pend_a, mpf);
    chk("seg_b", seg_b, es_n);
    chk("an_b", an_b, ea_n);
    chk("tick_b", tick_b, e_tick);
    chk("pend_b", pend_b, mpf);
  endtask

  // One clock: advance model on the edge, compare just after it
  task automatic cyc();
    bit bnd;
    @(posedge clk);
    if (rst) begin
      mreset();
    end else begin
      bnd      = ((t % F) == F - 1);
      e_pos    = (t / P) % D;
      e_val    = mdisp;
      e_tick   = last_bnd;
      last_bnd = bnd;
      if (load && bnd) begin
        mdisp = bcd_in; mpend = bcd_in; mpf = 0;
      end else if (load) begin
        mpend = bcd_in; mpf = 1;
      end else if (bnd && mpf) begin
        mdisp = mpend; mpf = 0;
      end
      t++;
    end
    #1;
    compare_all();
  endtask

  task automatic goto_phase(input int ph);
    int n = 0;
    while ((t % F) != ph && n < 2*F) begin
      cyc();
      n++;
    end
    chk("phase_wait", ((t % F) == ph), 1);
  endtask

  task automatic wait_tick();
    int n = 0;
    cyc();
    while (!tick_a && n < 3*F) begin
      cyc();
      n++;
    end
    chk("tick_wait", tick_a, 1'b1);
  endtask

  task automatic load1(input logic [15:0] v);
    load = 1'b1;
    bcd_in = v;
    cyc();
    load = 1'b0;
  endtask

  // Literal per-digit expectations for one frame, digit 0 in low bits
  task automatic lit(input string nm, input logic [27:0] ea,
                     input logic [27:0] eb);
    logic [3:0] an1, an1_n;
    wait_tick();
    for (int d = 0; d < D; d++) begin
      an1   = 4'(1 << d);
      an1_n = ~an1;
      chk({nm, "_seg_a"}, seg_a, ea[7*d +: 7]);
      chk({nm, "_an_a"}, an_a, an1);
      chk({nm, "_seg_b"}, seg_b, eb[7*d +: 7]);
      chk({nm, "_an_b"}, an_b, an1_n);
      repeat (P) cyc();
    end
  endtask

  logic [27:0] zero_a;
  logic [27:0] v_a;

  initial begin
    mreset();
`ifdef SEG7_SCAN_LZB_EN
    zero_a = {7'h00, 7'h00, 7'h00, 7'h3F};
`else
    zero_a = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif

    rst = 1'b1;
    #2;
    compare_all();
    repeat (3) cyc();
    chk("rst_an_a", an_a, 4'h0);
    chk("rst_an_b", an_b, 4'hF);
    chk("rst_seg_b", seg_b, 7'h7F);

    rst = 1'b0;
    cyc();
    chk("first_an", an_a, 4'b0001);
    chk("first_seg", seg_a, 7'h3F);
    repeat (2*F + 3) cyc();
    lit("scan", zero_a, ~zero_a);

    goto_phase(6);
    load1(16'h1234);
    chk("pend_after_load", pend_a, 1'b1);
    v_a = {7'h06, 7'h5B, 7'h4F, 7'h66};
    lit("f1234", v_a, ~v_a);
    chk("pend_cleared", pend_a, 1'b0);

    goto_phase(2);
    load1(16'h1111);
    repeat (3) cyc();
    load1(16'h9876);
    v_a = {7'h6F, 7'h7F, 7'h07, 7'h7D};
    lit("f9876", v_a, ~v_a);

    goto_phase(F - 1);
    load1(16'h0005);
    chk("coinc_pend", pend_a, 1'b0);
    cyc();
    chk("coinc_tick", tick_a, 1'b1);
    chk("coinc_seg", seg_a, 7'h6D);
    chk("coinc_pend2", pend_a, 1'b0);
    repeat (2) cyc();

    load1(16'hFA0B);
    lit("fFA0B", {7'h40, 7'h40, 7'h3F, 7'h40},
                 {7'h3F, 7'h3F, 7'h40, 7'h3F});

`ifdef SEG7_SCAN_LZB_EN
    load1(16'h0070);
    v_a = {7'h00, 7'h00, 7'h07, 7'h3F};
    lit("lzb70", v_a, ~v_a);
    load1(16'h0000);
    v_a = {7'h00, 7'h00, 7'h00, 7'h3F};
    lit("lzb0", v_a, ~v_a);
`endif

    goto_phase(3);
    load1(16'h4321);
    repeat (2) cyc();
    rst = 1'b1;
    #1;
    mreset();
    compare_all();
    chk("mid_rst_an", an_a, 4'h0);
    chk("mid_rst_pend", pend_a, 1'b0);
    repeat (2) cyc();
    rst = 1'b0;
    repeat (F + 2) cyc();
    chk("post_rst_pend", pend_a, 1'b0);
    lit("post_rst", zero_a, ~zero_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
